// File: rtl/label_vote_filter_pkg.sv
// label_vote_filter_pkg: shared widths, vote defaults, FSM state type and ceil_log2 helper
package label_vote_filter_pkg;
    localparam int LABEL_WIDTH      = 2;
    localparam int DISTANCE_WIDTH   = 8;
    localparam int NUM_LABELS       = 2 ** LABEL_WIDTH;
    localparam int VOTE_WINDOW      = 5;
    localparam int VOTE_DIST_THRESH = 100;

    typedef enum logic {FILL, FULL} vote_state_e;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/label_vote_filter_hist.sv
// label_vote_hist: per-channel entry window, incremental label histogram and tie-aware argmax
module label_vote_hist
    import label_vote_filter_pkg::*;
#(
    parameter int WINDOW      = VOTE_WINDOW,
    parameter int DIST_THRESH = VOTE_DIST_THRESH,
    localparam int VW         = ceil_log2(WINDOW + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_accept,
    input  logic                      i_clear,
    input  logic                      i_evict,
    input  logic [LABEL_WIDTH-1:0]    i_label,
    input  logic [DISTANCE_WIDTH-1:0] i_dist,
    input  logic [LABEL_WIDTH-1:0]    i_prev,
    output logic [LABEL_WIDTH-1:0]    o_label,
    output logic [VW-1:0]             o_votes
);
    logic [LABEL_WIDTH-1:0] r_lab  [WINDOW];
    logic                   r_ok   [WINDOW];
    logic [VW-1:0]          r_hist [NUM_LABELS];
    logic [VW-1:0]          w_hist [NUM_LABELS];
    logic                   w_counted;

    assign w_counted = 32'(i_dist) <= 32'(DIST_THRESH);

    // evict is only raised when the window is full, so r_lab[WINDOW-1] is the oldest live entry
    always_comb begin
        for (int l = 0; l < NUM_LABELS; l++)
            w_hist[l] = (i_clear ? '0 : r_hist[l])
                      + VW'(i_accept && w_counted && i_label == LABEL_WIDTH'(l))
                      - VW'(i_evict && r_ok[WINDOW-1] && r_lab[WINDOW-1] == LABEL_WIDTH'(l));
    end

    // seeding with the previous label and using strict > gives it priority on ties
    always_comb begin
        o_label = i_prev;
        o_votes = w_hist[i_prev];
        for (int l = 0; l < NUM_LABELS; l++)
            if (w_hist[l] > o_votes) begin
                o_label = LABEL_WIDTH'(l);
                o_votes = w_hist[l];
            end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                r_lab[i] <= '0;
                r_ok[i]  <= 1'b0;
            end
            for (int l = 0; l < NUM_LABELS; l++) r_hist[l] <= '0;
        end else begin
            r_hist <= w_hist;
            if (i_accept) begin
                r_lab[0] <= i_label;
                r_ok[0]  <= w_counted;
                for (int i = 1; i < WINDOW; i++) begin
                    r_lab[i] <= r_lab[i-1];
                    r_ok[i]  <= r_ok[i-1];
                end
            end
        end
    end
endmodule

// File: rtl/label_vote_filter.sv
// label_vote_filter: sliding-window majority vote over arousal/valence labels with a one-deep output register
module label_vote_filter
    import label_vote_filter_pkg::*;
#(
    parameter int WINDOW      = VOTE_WINDOW,
    parameter int DIST_THRESH = VOTE_DIST_THRESH
) (
    input  logic                               Clk_CI,
    input  logic                               Reset_RI,
    input  logic                               ValidIn_SI,
    output logic                               ReadyOut_SO,
    input  logic [LABEL_WIDTH-1:0]             LabelIn_A_DI,
    input  logic [LABEL_WIDTH-1:0]             LabelIn_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]          DistanceIn_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]          DistanceIn_V_DI,
    input  logic                               Clear_SI,
    output logic                               ValidOut_SO,
    input  logic                               ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0]             LabelOut_A_DO,
    output logic [LABEL_WIDTH-1:0]             LabelOut_V_DO,
    output logic [ceil_log2(WINDOW+1)-1:0]     Votes_A_DO,
    output logic [ceil_log2(WINDOW+1)-1:0]     Votes_V_DO,
    output logic                               Full_SO
);
    localparam int VW = ceil_log2(WINDOW + 1);

    vote_state_e            r_state;
    logic [VW-1:0]          r_cnt;
    logic                   w_accept;
    logic                   w_evict;
    logic [LABEL_WIDTH-1:0] w_label_a, w_label_v;
    logic [VW-1:0]          w_votes_a, w_votes_v;

    assign ReadyOut_SO = ~ValidOut_SO | ReadyIn_SI;
    assign w_accept    = ValidIn_SI & ReadyOut_SO;
    assign w_evict     = w_accept & (r_state == FULL) & ~Clear_SI;
    assign Full_SO     = r_state == FULL;

    label_vote_hist #(.WINDOW(WINDOW), .DIST_THRESH(DIST_THRESH)) u_hist_a (
        .i_clk(Clk_CI), .i_rst(Reset_RI), .i_accept(w_accept), .i_clear(Clear_SI), .i_evict(w_evict),
        .i_label(LabelIn_A_DI), .i_dist(DistanceIn_A_DI), .i_prev(LabelOut_A_DO),
        .o_label(w_label_a), .o_votes(w_votes_a)
    );

    label_vote_hist #(.WINDOW(WINDOW), .DIST_THRESH(DIST_THRESH)) u_hist_v (
        .i_clk(Clk_CI), .i_rst(Reset_RI), .i_accept(w_accept), .i_clear(Clear_SI), .i_evict(w_evict),
        .i_label(LabelIn_V_DI), .i_dist(DistanceIn_V_DI), .i_prev(LabelOut_V_DO),
        .o_label(w_label_v), .o_votes(w_votes_v)
    );

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            r_state       <= FILL;
            r_cnt         <= '0;
            ValidOut_SO   <= 1'b0;
            LabelOut_A_DO <= '0;
            LabelOut_V_DO <= '0;
            Votes_A_DO    <= '0;
            Votes_V_DO    <= '0;
        end else begin
            if (Clear_SI) begin
                r_state <= FILL;
                r_cnt   <= VW'(w_accept);
            end else if (w_accept && r_state == FILL) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == VW'(WINDOW - 1)) r_state <= FULL;
            end
            if (w_accept) begin
                ValidOut_SO   <= 1'b1;
                LabelOut_A_DO <= w_label_a;
                LabelOut_V_DO <= w_label_v;
                Votes_A_DO    <= w_votes_a;
                Votes_V_DO    <= w_votes_v;
            end else if (ReadyIn_SI) begin
                ValidOut_SO <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_label_vote_filter.sv
// tb_label_vote_filter: directed and random stimulus against a queue-based vote model
module tb_label_vote_filter;
    import label_vote_filter_pkg::*;
    localparam int W  = 5;
    localparam int VW = ceil_log2(W + 1);

    logic Clk_CI = 1'b0, Reset_RI = 1'b1, ValidIn_SI = 1'b0, Clear_SI = 1'b0, ReadyIn_SI = 1'b0;
    logic ReadyOut_SO, ValidOut_SO, Full_SO;
    logic [LABEL_WIDTH-1:0] LabelIn_A_DI = '0, LabelIn_V_DI = '0, LabelOut_A_DO, LabelOut_V_DO;
    logic [DISTANCE_WIDTH-1:0] DistanceIn_A_DI = '0, DistanceIn_V_DI = '0;
    logic [VW-1:0] Votes_A_DO, Votes_V_DO;

    int n_vec = 0, n_err = 0, n_dut_acc = 0;
    int qa_l[$], qv_l[$];
    bit qa_ok[$], qv_ok[$];
    bit m_valid = 0;
    int m_la = 0, m_lv = 0, m_va = 0, m_vv = 0;

    always #5 Clk_CI = ~Clk_CI;

    label_vote_filter #(.WINDOW(W), .DIST_THRESH(100)) dut (
        .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
        .LabelIn_A_DI(LabelIn_A_DI), .LabelIn_V_DI(LabelIn_V_DI),
        .DistanceIn_A_DI(DistanceIn_A_DI), .DistanceIn_V_DI(DistanceIn_V_DI),
        .Clear_SI(Clear_SI), .ValidOut_SO(ValidOut_SO), .ReadyIn_SI(ReadyIn_SI),
        .LabelOut_A_DO(LabelOut_A_DO), .LabelOut_V_DO(LabelOut_V_DO),
        .Votes_A_DO(Votes_A_DO), .Votes_V_DO(Votes_V_DO), .Full_SO(Full_SO)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // winner = label with the most counted entries; previous label kept if tied at the top, else lowest tied
    function automatic void vote(input int lab[$], input bit ok[$], input int prev, output int wl, output int wv);
        int hist[NUM_LABELS];
        int mx;
        hist = '{default: 0};
        mx = 0;
        foreach (lab[i]) if (ok[i]) hist[lab[i]]++;
        foreach (hist[l]) if (hist[l] > mx) mx = hist[l];
        wv = mx;
        wl = prev;
        if (hist[prev] != mx)
            for (int l = NUM_LABELS - 1; l >= 0; l--) if (hist[l] == mx) wl = l;
    endfunction

    task automatic model_reset();
        qa_l.delete(); qv_l.delete(); qa_ok.delete(); qv_ok.delete();
        m_valid = 0; m_la = 0; m_lv = 0; m_va = 0; m_vv = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, ValidOut_SO, m_valid);
        chk({tag, ".label_a"}, LabelOut_A_DO, m_la);
        chk({tag, ".label_v"}, LabelOut_V_DO, m_lv);
        chk({tag, ".votes_a"}, Votes_A_DO, m_va);
        chk({tag, ".votes_v"}, Votes_V_DO, m_vv);
        chk({tag, ".full"}, Full_SO, qa_l.size() == W);
    endtask

    task automatic step(input string tag, input bit vin, input int la, input int da,
                        input int lv, input int dv, input bit clr, input bit rdy);
        bit acc;
        ValidIn_SI = vin; Clear_SI = clr; ReadyIn_SI = rdy;
        LabelIn_A_DI = LABEL_WIDTH'(la); DistanceIn_A_DI = DISTANCE_WIDTH'(da);
        LabelIn_V_DI = LABEL_WIDTH'(lv); DistanceIn_V_DI = DISTANCE_WIDTH'(dv);
        #1;
        chk({tag, ".ready_out"}, ReadyOut_SO, !m_valid || rdy);
        if (vin && ReadyOut_SO === 1'b1) n_dut_acc++;
        acc = vin && (!m_valid || rdy);
        @(posedge Clk_CI);
        if (clr) begin
            qa_l.delete(); qv_l.delete(); qa_ok.delete(); qv_ok.delete();
        end
        if (acc) begin
            qa_l.push_front(la); qa_ok.push_front(da <= 100);
            qv_l.push_front(lv); qv_ok.push_front(dv <= 100);
            if (qa_l.size() > W) begin
                void'(qa_l.pop_back()); void'(qa_ok.pop_back());
                void'(qv_l.pop_back()); void'(qv_ok.pop_back());
            end
            vote(qa_l, qa_ok, m_la, m_la, m_va);
            vote(qv_l, qv_ok, m_lv, m_lv, m_vv);
            m_valid = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        int seq_a[5];
        int seq_d[5];
        int exp_votes[5];
        // reset asserted from time 0: outputs must already be cleared before any clock edge
        #2;
        chk("rst0.valid", ValidOut_SO, 0);
        chk("rst0.ready_out", ReadyOut_SO, 1);
        chk("rst0.full", Full_SO, 0);
        #10 Reset_RI = 1'b0;
        @(posedge Clk_CI); #1;
        chk_all("post_rst");

        // majority: 1,1,2,1,3
        seq_a = '{1, 1, 2, 1, 3};
        exp_votes = '{1, 2, 2, 3, 3};
        for (int i = 0; i < 5; i++) begin
            step("maj", 1, seq_a[i], 50, $urandom_range(3), $urandom_range(200), 0, 1);
            chk("maj.label_a_const", LabelOut_A_DO, 1);
            chk("maj.votes_a_const", Votes_A_DO, exp_votes[i]);
            chk("maj.full_const", Full_SO, i == 4);
        end

        // threshold: only the two close label-2 samples are counted
        step("thr_clr", 0, 0, 0, 0, 0, 1, 1);
        seq_a = '{2, 2, 0, 0, 0};
        seq_d = '{10, 10, 150, 150, 150};
        for (int i = 0; i < 5; i++) step("thr", 1, seq_a[i], seq_d[i], 1, 60, 0, 1);
        chk("thr.label_a_const", LabelOut_A_DO, 2);
        chk("thr.votes_a_const", Votes_A_DO, 2);

        // threshold boundary: 100 counted, 101 not
        step("bnd_clr", 1, 1, 100, 2, 101, 1, 1);
        chk("bnd.votes_a100", Votes_A_DO, 1);
        chk("bnd.votes_v101", Votes_V_DO, 0);
        step("bnd", 1, 2, 101, 2, 100, 0, 1);
        chk("bnd.label_a_const", LabelOut_A_DO, 1);
        chk("bnd.votes_a_const", Votes_A_DO, 1);

        // tie: window 1,1,2,2 with previous output 1, then 3
        step("tie_clr", 0, 0, 0, 0, 0, 1, 1);
        seq_a = '{1, 1, 2, 2, 3};
        for (int i = 0; i < 5; i++) step("tie", 1, seq_a[i], 20, 0, 20, 0, 1);
        chk("tie.label_a_const", LabelOut_A_DO, 1);
        chk("tie.votes_a_const", Votes_A_DO, 2);
        step("tie0", 1, 0, 20, 0, 20, 1, 1);
        chk("tie0.label_a_const", LabelOut_A_DO, 0);
        step("tie23", 1, 2, 20, 0, 20, 1, 1);
        step("tie23", 1, 3, 20, 0, 20, 0, 1);
        chk("tie23.label_a_const", LabelOut_A_DO, 2);

        // backpressure: four cycles of offered data with consumer stalled
        step("bp_drain", 0, 0, 0, 0, 0, 0, 1);
        n_dut_acc = 0;
        for (int i = 0; i < 4; i++) step("bp", 1, i, 30, 3 - i, 30, 0, 0);
        chk("bp.accepts", n_dut_acc, 1);
        n_dut_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step("bp_rel", 1, $urandom_range(3), 30, $urandom_range(3), 30, 0, 1);
            chk("bp_rel.valid_const", ValidOut_SO, 1);
        end
        chk("bp_rel.accepts", n_dut_acc, 5);

        // clear with accept while full
        chk("clr.full_before", Full_SO, 1);
        step("clr", 1, 3, 40, 3, 40, 1, 1);
        chk("clr.votes_const", Votes_A_DO, 1);
        chk("clr.full_const", Full_SO, 0);
        chk("clr.label_const", LabelOut_A_DO, 3);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rnd", $urandom_range(3) != 0, $urandom_range(3), $urandom_range(90, 110),
                 $urandom_range(3), $urandom_range(200), $urandom_range(19) == 0, $urandom_range(9) < 7);

        // reset in the middle of a stalled transfer
        step("mid", 1, 2, 10, 1, 10, 0, 0);
        step("mid", 1, 1, 10, 2, 10, 0, 0);
        Reset_RI = 1'b1;
        #1;
        model_reset();
        chk("mid_rst.ready_out", ReadyOut_SO, 1);
        chk_all("mid_rst");
        #2 Reset_RI = 1'b0;
        for (int i = 0; i < 6; i++) step("after", 1, 3, 10, 0, 10, 0, 1);
        chk("after.votes_const", Votes_A_DO, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/label_vote_filter.md
LABEL_VOTE_FILTER -- requirements
Module: label_vote_filter

Interface
REQ-001 Parameter WINDOW, default 5, is the sliding-window depth in classifications, legal range 2..16.
REQ-002 Parameter DIST_THRESH, default 100, is the maximum Hamming distance for which a classification is counted as a vote.
REQ-003 Clk_CI  in  1  is the single clock; all state changes on its rising edge.
REQ-004 Reset_RI  in  1  is the asynchronous, active-high reset.
REQ-005 ValidIn_SI  in  1  means the associative-memory result is valid.
REQ-006 ReadyOut_SO  out  1  means this block accepts an input this cycle.
REQ-007 LabelIn_A_DI, LabelIn_V_DI  in  `LABEL_WIDTH each  are the arousal and valence labels.
REQ-008 DistanceIn_A_DI, DistanceIn_V_DI  in  `DISTANCE_WIDTH each  are the arousal and valence distances.
REQ-009 Clear_SI  in  1  is a synchronous window flush.
REQ-010 ValidOut_SO  out  1  means the smoothed result is valid.
REQ-011 ReadyIn_SI  in  1  means the downstream consumer accepts the result.
REQ-012 LabelOut_A_DO, LabelOut_V_DO  out  `LABEL_WIDTH each  are the voted labels.
REQ-013 Votes_A_DO, Votes_V_DO  out  `ceilLog2(WINDOW+1) each  give the vote count of each winning label.
REQ-014 Full_SO  out  1  is high when the window holds WINDOW entries.

Function
REQ-015 An input SHALL be accepted when ValidIn_SI and ReadyOut_SO are both high.
REQ-016 ReadyOut_SO SHALL equal ~ValidOut_SO | ReadyIn_SI, giving a one-deep output register and full throughput.
REQ-017 The A and V channels SHALL each keep a WINDOW-deep shift register of entries (label, counted flag).
  - The counted flag is set when distance <= DIST_THRESH.
  - The threshold comparison is unsigned.
REQ-018 On accept, the new entry SHALL be shifted in; once full, the oldest entry is discarded in the same cycle.
REQ-019 Each channel SHALL keep one histogram counter per label value (2**`LABEL_WIDTH counters).
  - Counters are updated incrementally: +1 for an incoming counted entry, -1 for an evicted counted entry.
  - A simultaneous +1 and -1 on the same label SHALL leave that counter unchanged.
  - No counter shall ever exceed WINDOW or go below 0.
REQ-020 Winner selection SHALL be made from the updated histogram:
  - The winner is the label with the maximum count.
  - On a tie, the previous output label wins if it is among the tied labels; otherwise the lowest tied label index wins.
REQ-021 If all counts are zero, the output SHALL be the previous label with Votes = 0.
REQ-022 Output latency SHALL be exactly 1 cycle: accept at edge t -> ValidOut_SO high after edge t with outputs registered.
  - Outputs SHALL be held stable while ValidOut_SO=1 and ReadyIn_SI=0.
REQ-023 ValidOut_SO SHALL drop after the edge where ValidOut_SO & ReadyIn_SI, unless a new input is accepted on that edge.
REQ-024 The state machine SHALL have two states: FILL (entry count < WINDOW) and FULL.
  - FILL -> FULL on the accept that makes the entry count WINDOW.
  - FULL -> FILL on Clear_SI.
  - Full_SO SHALL be high exactly in FULL.
REQ-025 Clear_SI SHALL zero the histograms and entry count; previous labels and the pending output are kept.
REQ-026 Clear_SI together with an accept SHALL clear first, then store the sample as the sole entry (count 1, FILL).

Reset
REQ-027 Reset SHALL asynchronously drive all of the following, including mid-transfer:
  - ValidOut_SO=0, LabelOut_*=0, Votes_*=0, Full_SO=0.
  - Histograms, entry count and previous labels = 0, state FILL.
REQ-028 ReadyOut_SO SHALL be 1 during and after reset.

Structure
REQ-029 `LABEL_WIDTH, `DISTANCE_WIDTH and `ceilLog2 SHALL come from the shared const.vh.
REQ-030 Defaults VOTE_WINDOW and VOTE_DIST_THRESH SHALL be added to const.vh.
REQ-031 Sub-module label_vote_hist (entry shift register, histogram, argmax) SHALL be instantiated once per channel (A, V).
  - The FSM, handshake and output register remain in label_vote_filter.

Verification (WINDOW=5, LABEL_WIDTH=2, DIST_THRESH=100)
REQ-032 Test 1 (reset): assert Reset_RI mid-transfer -> all outputs 0 and ReadyOut_SO=1 immediately, without waiting for a clock edge.
REQ-033 Test 2 (majority): A labels 1,1,2,1,3, all distances 50 -> LabelOut_A_DO=1 with Votes_A_DO=1,2,2,3,3; Full_SO rises after the 5th accept.
REQ-034 Test 3 (threshold): A labels 2,2,0,0,0, distances 10,10,150,150,150 -> final LabelOut_A_DO=2, Votes_A_DO=2.
REQ-035 Test 4 (tie): window 1,1,2,2 after output 1, then label 3 -> output stays 1; a fresh window 2,3 from previous 0 -> output 2.
REQ-036 Test 5 (backpressure): ReadyIn_SI=0 for 4 cycles with ValidIn_SI=1 -> exactly one accept, outputs held; on release, streaming at 1 per cycle.
REQ-037 Test 6 (clear): Clear_SI together with an accept of label 3 in FULL -> Votes=1, Full_SO=0, LabelOut=3.
